score_collision: RTL and testbench
==================================

Name: score_collision

Overview:
- Sits directly downstream of the bird physics stage in the GAME_clk domain.
- Consumes birdY and the game state, plus the two pipe positions from the pipe generator.
- Produces a registered collision pulse and a sticky hit flag; the game-state controller uses these to enter END_SCREEN.
- Maintains the current score and high score in BCD for the score renderer.

Parameters:
- BIRD_SIZE_X, 34: bird sprite width, px
- BIRD_SIZE_Y, 24: bird sprite height, px
- BIRD_X, 100: fixed left x of the bird, px
- PIPE_WIDTH, 52: pipe width, px
- PIPE_GAP, 120: vertical gap height, px
- SCREEN_H, 480: visible height, px

Ports:
- GAME_clk  in  1  game tick clock
- rst  in  1  reset: synchronous, active-high
- game_state  in  4  one-hot: START_SCREEN=0001, IN_GAME=0010, PAUSE=0100, END_SCREEN=1000
- birdY  in  32 signed  bird top y
- pipe0X, pipe1X  in  32 signed  pipe left x
- pipe0GapY, pipe1GapY  in  32 signed  gap top y
- collision  out  1  one-cycle pulse on first hit
- hit  out  1  sticky hit flag
- score  out  12  3-digit BCD, current score
- high_score  out  12  3-digit BCD, best score

Behaviour:
- Reset: every output = 0; passed0/passed1 = 0; prev_state = START_SCREEN.
- Geometry is combinational from the inputs. All outputs are registered, so latency is 1 GAME_clk from input change to output.
- Bottom boundary: birdY + BIRD_SIZE_Y >= SCREEN_H.
- Top boundary: birdY < 0.
- Pipe i overlap in x: BIRD_X + BIRD_SIZE_X > pipeiX AND BIRD_X < pipeiX + PIPE_WIDTH.
- Pipe i overlap in y: birdY < pipeiGapY OR birdY + BIRD_SIZE_Y > pipeiGapY + PIPE_GAP.
- hit_now = (top OR bottom OR any pipe with both x and y overlap), qualified by game_state == IN_GAME.
- All comparisons are 32-bit signed. Edges are exact: touching the gap edge is not a hit.
- When hit_now and hit == 0: collision = 1 for exactly one cycle; hit goes to 1.
- When hit == 1: collision stays 0; hit holds until START_SCREEN is seen.
- Pass detection for pipe i: passedi == 0 AND pipeiX + PIPE_WIDTH < BIRD_X AND IN_GAME AND hit == 0 AND hit_now == 0. On this condition, set passedi and increment score.
- passedi clears whenever pipeiX + PIPE_WIDTH >= BIRD_X, i.e. the pipe has wrapped back to the right.
- Both pipes passing in the same cycle: score += 2.
- Hit priority: when hit_now is set in a cycle, that cycle does not score.
- Score arithmetic: BCD per digit, carrying 9 to 0. Saturates at 999, including the +2 case from 998 (result is 999).
- PAUSE: score, hit, passed flags and high_score all freeze. collision = 0.
- START_SCREEN: score = 0, hit = 0, passed flags = 0. high_score is kept.
- Entry to END_SCREEN (prev_state != END_SCREEN): if score > high_score, high_score <= score. This is evaluated once per entry.
- Reset asserted mid-game clears everything, high_score included, on the next edge.

Decomposition:
- Shared package holds:
  - game_state one-hot localparams (START_SCREEN, IN_GAME, PAUSE, END_SCREEN);
  - SCREEN_H / SCREEN_W constants;
  - a BCD width constant (12).
- Natural sub-module: bcd_counter3.
  - Inputs: inc1, inc2, clear.
  - Behaviour: synchronous clear, saturating at 999.
  - Instantiated once for score; high_score is a plain register with a BCD compare.

Test Plan:
- IN_GAME, birdY=228, pipe0X=300, pipe1X=600 -> collision=0, hit=0, score=000 for 10 cycles.
- IN_GAME, birdY steps 455 -> 456 -> collision=1 for one cycle, then 0; hit=1 holds; birdY=460 later produces no further pulse.
- IN_GAME, pipe0X=80, pipe0GapY=100, birdY=196 (196+24=220, exactly the gap edge) -> no hit. birdY=197 -> collision pulse next cycle.
- IN_GAME, pipe0X decrements from 60; at pipe0X=47 (47+52=99<100) -> score=001 one cycle later, no recount while pipe0X keeps dropping. pipe0X=640 -> passed0 clears; next pass -> score=002.
- Score 998, both pipes pass in one cycle -> score=999. Further passes -> stays 999. PAUSE mid-way -> all values frozen.
- Score=005, high_score=003. Enter END_SCREEN -> high_score=005. Then START_SCREEN -> score=000, hit=0, high_score=005. rst=1 for one cycle -> all outputs 0.

Source files
------------

// File: rtl/score_collision_pkg.sv
// Shared constants for the collision/score stage: one-hot game states,
// screen geometry and the width of the 3-digit BCD score bus.
package score_collision_pkg;

  localparam logic [3:0] START_SCREEN = 4'b0001;
  localparam logic [3:0] IN_GAME      = 4'b0010;
  localparam logic [3:0] PAUSE        = 4'b0100;
  localparam logic [3:0] END_SCREEN   = 4'b1000;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;
  localparam int BCD_W    = 12;

endpackage

// File: rtl/score_collision_bcd_counter3.sv
// Three-digit BCD up-counter that adds 1 or 2 per enable and saturates at 999.
module score_collision_bcd_counter3
  import score_collision_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc1,
  input  logic             inc2,
  output logic [BCD_W-1:0] count
);

  logic [3:0]       amt;
  logic [4:0]       s0, s1, s2;
  logic [4:0]       s0_adj;
  logic             c0, c1, c2;
  logic [3:0]       n0, n1, n2;
  logic [BCD_W-1:0] count_next;

  always_comb begin
    amt    = inc2 ? 4'd2 : 4'd1;
    s0     = {1'b0, count[3:0]} + {1'b0, amt};
    s0_adj = s0 - 5'd10;
    c0     = (s0 > 5'd9);
    n0     = c0 ? s0_adj[3:0] : s0[3:0];
    s1     = {1'b0, count[7:4]} + {4'b0000, c0};
    c1     = (s1 > 5'd9);
    n1     = c1 ? 4'd0 : s1[3:0];
    s2     = {1'b0, count[11:8]} + {4'b0000, c1};
    c2     = (s2 > 5'd9);
    n2     = c2 ? 4'd0 : s2[3:0];
    // A carry out of the hundreds digit means the sum passed 999.
    count_next = c2 ? 12'h999 : {n2, n1, n0};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc1 || inc2) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/score_collision.sv
// Bird-vs-world collision detection with a one-shot collision pulse, sticky
// hit flag, pipe-pass scoring in BCD and a high score latched on game end.
module score_collision #(
  parameter int BIRD_SIZE_X = 34,
  parameter int BIRD_SIZE_Y = 24,
  parameter int BIRD_X      = 100,
  parameter int PIPE_WIDTH  = 52,
  parameter int PIPE_GAP    = 120,
  parameter int SCREEN_H    = score_collision_pkg::SCREEN_H
) (
  input  logic               GAME_clk,
  input  logic               rst,
  input  logic [3:0]         game_state,
  input  logic signed [31:0] birdY,
  input  logic signed [31:0] pipe0X,
  input  logic signed [31:0] pipe1X,
  input  logic signed [31:0] pipe0GapY,
  input  logic signed [31:0] pipe1GapY,
  output logic               collision,
  output logic               hit,
  output logic [11:0]        score,
  output logic [11:0]        high_score
);
  import score_collision_pkg::*;

  logic signed [31:0] bird_bottom;
  logic               wall_hit, pipe0_hit, pipe1_hit, hit_now, in_game;
  logic               wrap0, wrap1, pass0, pass1;
  logic               passed0, passed1;
  logic [3:0]         prev_state;

  function automatic logic pipe_hit(input logic signed [31:0] px,
                                    input logic signed [31:0] gy,
                                    input logic signed [31:0] by);
    logic x_ov, y_ov;
    x_ov = (BIRD_X + BIRD_SIZE_X > px) && (BIRD_X < px + PIPE_WIDTH);
    y_ov = (by < gy) || (by + BIRD_SIZE_Y > gy + PIPE_GAP);
    return x_ov && y_ov;
  endfunction

  assign bird_bottom = birdY + BIRD_SIZE_Y;
  assign in_game     = (game_state == IN_GAME);
  assign wall_hit    = (birdY < 0) || (bird_bottom >= SCREEN_H);
  assign pipe0_hit   = pipe_hit(pipe0X, pipe0GapY, birdY);
  assign pipe1_hit   = pipe_hit(pipe1X, pipe1GapY, birdY);
  assign hit_now     = in_game && (wall_hit || pipe0_hit || pipe1_hit);

  // A pipe is re-armed for scoring once it is back right of the bird's left edge.
  assign wrap0 = (pipe0X + PIPE_WIDTH >= BIRD_X);
  assign wrap1 = (pipe1X + PIPE_WIDTH >= BIRD_X);
  assign pass0 = !passed0 && !wrap0 && in_game && !hit && !hit_now;
  assign pass1 = !passed1 && !wrap1 && in_game && !hit && !hit_now;

  score_collision_bcd_counter3 u_score (
    .clk   (GAME_clk),
    .rst   (rst),
    .clear (game_state == START_SCREEN),
    .inc1  (pass0 ^ pass1),
    .inc2  (pass0 & pass1),
    .count (score)
  );

  always_ff @(posedge GAME_clk) begin
    if (rst) begin
      collision  <= 1'b0;
      hit        <= 1'b0;
      passed0    <= 1'b0;
      passed1    <= 1'b0;
      high_score <= '0;
      prev_state <= START_SCREEN;
    end else begin
      prev_state <= game_state;
      collision  <= 1'b0;
      case (game_state)
        START_SCREEN: begin
          hit     <= 1'b0;
          passed0 <= 1'b0;
          passed1 <= 1'b0;
        end
        IN_GAME: begin
          if (hit_now && !hit) begin
            collision <= 1'b1;
            hit       <= 1'b1;
          end
          passed0 <= wrap0 ? 1'b0 : (passed0 | pass0);
          passed1 <= wrap1 ? 1'b0 : (passed1 | pass1);
        end
        END_SCREEN: begin
          if (wrap0) passed0 <= 1'b0;
          if (wrap1) passed1 <= 1'b0;
          // BCD digits order the same as binary, so a plain compare works.
          if (prev_state != END_SCREEN && score > high_score) high_score <= score;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_collision.sv
// Directed bench for score_collision: the driver pushes the expected
// {collision, hit, score, high_score} per cycle; a monitor pops and compares.
module tb_score_collision;
  import score_collision_pkg::*;

  logic               GAME_clk;
  logic               rst;
  logic [3:0]         game_state;
  logic signed [31:0] birdY, pipe0X, pipe1X, pipe0GapY, pipe1GapY;
  logic               collision, hit;
  logic [11:0]        score, high_score;

  logic [25:0] exp_q[$];
  string       name_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [25:0] mon_exp;
  logic [25:0] mon_act;
  string       mon_name;

  score_collision dut (
    .GAME_clk   (GAME_clk),
    .rst        (rst),
    .game_state (game_state),
    .birdY      (birdY),
    .pipe0X     (pipe0X),
    .pipe1X     (pipe1X),
    .pipe0GapY  (pipe0GapY),
    .pipe1GapY  (pipe1GapY),
    .collision  (collision),
    .hit        (hit),
    .score      (score),
    .high_score (high_score)
  );

  // clock / reset
  initial begin
    GAME_clk = 1'b0;
    forever #5 GAME_clk = ~GAME_clk;
  end

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // driver: inputs are set at a negedge, then the response expected after
  // the next posedge is queued and we advance to the following negedge
  task automatic expect_cycle(input logic ec, input logic eh,
                              input logic [11:0] es, input logic [11:0] ehs,
                              input string nm);
    exp_q.push_back({ec, eh, es, ehs});
    name_q.push_back(nm);
    @(negedge GAME_clk);
  endtask

  task automatic pass_pipe0(input int start, input int n, input logic [11:0] hs);
    for (int i = 0; i < n; i++) begin
      pipe0X = 640;
      expect_cycle(1'b0, 1'b0, to_bcd(start + i), hs, "pre_pass");
      pipe0X = 47;
      expect_cycle(1'b0, 1'b0, to_bcd(start + i + 1), hs, "pass_count");
    end
  endtask

  // scoreboard monitor
  always @(posedge GAME_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {collision, hit, score, high_score};
      tests_run++;
      if (mon_act !== mon_exp) begin
        tests_failed++;
        $display("FAIL %s: got col=%b hit=%b score=%h hs=%h, expected col=%b hit=%b score=%h hs=%h",
                 mon_name, mon_act[25], mon_act[24], mon_act[23:12], mon_act[11:0],
                 mon_exp[25], mon_exp[24], mon_exp[23:12], mon_exp[11:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; game_state = START_SCREEN; birdY = 228;
    pipe0X = 300; pipe0GapY = 180; pipe1X = 600; pipe1GapY = 180;
    @(negedge GAME_clk);
    expect_cycle(0, 0, 12'h000, 12'h000, "reset");
    expect_cycle(0, 0, 12'h000, 12'h000, "reset_hold");
    rst = 1'b0;
    expect_cycle(0, 0, 12'h000, 12'h000, "start_idle");

    game_state = IN_GAME;
    for (int i = 0; i < 10; i++) expect_cycle(0, 0, 12'h000, 12'h000, "fly_clear");
    birdY = 455; expect_cycle(0, 0, 12'h000, 12'h000, "bottom_edge");
    birdY = 456; expect_cycle(1, 1, 12'h000, 12'h000, "bottom_hit");
    expect_cycle(0, 1, 12'h000, 12'h000, "pulse_once");
    birdY = 460; expect_cycle(0, 1, 12'h000, 12'h000, "no_repulse");
    expect_cycle(0, 1, 12'h000, 12'h000, "hit_sticky");

    game_state = START_SCREEN; birdY = 228;
    expect_cycle(0, 0, 12'h000, 12'h000, "start_clear");
    game_state = IN_GAME; pipe0X = 80; pipe0GapY = 100; birdY = 196;
    expect_cycle(0, 0, 12'h000, 12'h000, "gap_bottom_edge");
    birdY = 100; expect_cycle(0, 0, 12'h000, 12'h000, "gap_top_edge");
    birdY = 197; expect_cycle(1, 1, 12'h000, 12'h000, "gap_bottom_hit");
    expect_cycle(0, 1, 12'h000, 12'h000, "hit_hold");

    game_state = START_SCREEN; pipe0X = 640; pipe0GapY = 180; birdY = 228;
    expect_cycle(0, 0, 12'h000, 12'h000, "restart");
    game_state = IN_GAME;
    for (int x = 60; x >= 48; x--) begin
      pipe0X = x;
      expect_cycle(0, 0, 12'h000, 12'h000, "no_pass_yet");
    end
    pipe0X = 47; expect_cycle(0, 0, 12'h001, 12'h000, "pass_first");
    for (int x = 46; x >= 40; x--) begin
      pipe0X = x;
      expect_cycle(0, 0, 12'h001, 12'h000, "no_recount");
    end
    pipe0X = 640; expect_cycle(0, 0, 12'h001, 12'h000, "wrap_clear");
    pipe0X = 47;  expect_cycle(0, 0, 12'h002, 12'h000, "pass_second");
    pipe0X = 640; expect_cycle(0, 0, 12'h002, 12'h000, "wrap_again");
    pipe0X = 47; birdY = -1;
    expect_cycle(1, 1, 12'h002, 12'h000, "hit_priority");
    birdY = 228; pipe0X = 46;
    expect_cycle(0, 1, 12'h002, 12'h000, "no_score_after_hit");
    game_state = PAUSE;
    expect_cycle(0, 1, 12'h002, 12'h000, "pause_hit_frozen");

    game_state = START_SCREEN; pipe0X = 640;
    expect_cycle(0, 0, 12'h000, 12'h000, "start_zero_hs");
    game_state = IN_GAME;
    pass_pipe0(0, 3, 12'h000);
    game_state = END_SCREEN;
    expect_cycle(0, 0, 12'h003, 12'h003, "hs_update");
    expect_cycle(0, 0, 12'h003, 12'h003, "hs_once");
    game_state = START_SCREEN; pipe0X = 640;
    expect_cycle(0, 0, 12'h000, 12'h003, "start_keep_hs");
    game_state = IN_GAME;
    pass_pipe0(0, 5, 12'h003);
    game_state = END_SCREEN;
    expect_cycle(0, 0, 12'h005, 12'h005, "hs_new_best");
    game_state = START_SCREEN; pipe0X = 640;
    expect_cycle(0, 0, 12'h000, 12'h005, "start_after_best");
    game_state = IN_GAME;
    pass_pipe0(0, 1, 12'h005);
    game_state = END_SCREEN;
    expect_cycle(0, 0, 12'h001, 12'h005, "hs_not_lower");
    game_state = START_SCREEN; pipe0X = 640; pipe1X = 640;
    expect_cycle(0, 0, 12'h000, 12'h005, "start_again");

    game_state = IN_GAME;
    for (int k = 0; k < 998; k += 2) begin
      pipe0X = 47; pipe1X = 47;
      expect_cycle(0, 0, to_bcd(k + 2), 12'h005, "double_pass");
      pipe0X = 640; pipe1X = 640;
      expect_cycle(0, 0, to_bcd(k + 2), 12'h005, "double_wrap");
    end
    game_state = PAUSE; pipe0X = 47; pipe1X = 47; birdY = 500;
    for (int i = 0; i < 3; i++) expect_cycle(0, 0, 12'h998, 12'h005, "pause_frozen");
    game_state = IN_GAME; birdY = 228;
    expect_cycle(0, 0, 12'h999, 12'h005, "sat_998_plus2");
    pipe0X = 640; pipe1X = 640; expect_cycle(0, 0, 12'h999, 12'h005, "sat_wrap");
    pipe0X = 47;  expect_cycle(0, 0, 12'h999, 12'h005, "sat_hold1");
    pipe0X = 640; expect_cycle(0, 0, 12'h999, 12'h005, "sat_wrap2");
    pipe0X = 47; pipe1X = 47; expect_cycle(0, 0, 12'h999, 12'h005, "sat_hold2");
    game_state = END_SCREEN;
    expect_cycle(0, 0, 12'h999, 12'h999, "hs_999");
    game_state = IN_GAME; rst = 1'b1;
    expect_cycle(0, 0, 12'h000, 12'h000, "mid_reset");
    rst = 1'b0; game_state = START_SCREEN;
    expect_cycle(0, 0, 12'h000, 12'h000, "post_reset");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge GAME_clk);
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
